csr_access_unit: RTL and testbench
==================================

# csr_access_unit

Initiator-side engine that executes RISC-V Zicsr instructions (CSRRW/CSRRS/CSRRC and their immediate forms) against the CSR storage array. It accepts one decoded CSR request from the execute stage over a valid/ready handshake and performs a read-modify-write on the synchronous-read CSR RAM port. It returns the old CSR value for rd over a second valid/ready handshake.

## Interface
- XLEN, 32, data width
- NUM, 4096, CSR count; ADDR_W = $clog2(NUM)

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_funct3  in  3  instruction funct3
- req_rs1  in  5  rs1 index, or zimm for immediate forms
- req_rs1_data  in  XLEN  rs1 register value
- req_addr  in  ADDR_W  CSR address
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rd_data  out  XLEN  old CSR value, or 0 if illegal
- rsp_illegal  out  1  illegal-instruction flag
- csr_addr  out  ADDR_W  RAM address
- csr_we  out  1  RAM write enable
- csr_wdata  out  XLEN  RAM write data
- csr_rdata  in  XLEN  RAM read data; valid one edge after csr_addr is sampled

## Operation
- Request fires when req_valid && req_ready; all req_* fields are latched.
- Operand:
  - funct3[2]=1: operand = zero-extended req_rs1.
  - funct3[2]=0: operand = req_rs1_data.
- New value by funct3[1:0]:
  - 01 (RW): operand.
  - 10 (RS): old | operand.
  - 11 (RC): old & ~operand.
- Write enable:
  - RW/RWI: always write.
  - RS/RC forms: write only if latched rs1 ≠ 0.
  - RS/RC with rs1 = 0 is a pure read, with no csr_we.
- funct3[1:0]=00 (000, 100): illegal.
  - No write.
  - rsp_illegal=1, rsp_rd_data=0.
  - The read cycle is still executed.
- FSM states: IDLE → READ → WRITE → RESP → IDLE.
  - IDLE: req_ready=1. On fire → READ.
  - READ: csr_addr = latched address; RAM samples it at the end of the cycle → WRITE.
  - WRITE: csr_rdata is valid and captured as old.
    - csr_wdata = new value.
    - csr_we = write enable (combinational from state).
    - → RESP.
  - RESP: rsp_valid=1; rsp_rd_data and rsp_illegal are held stable. On rsp_ready → IDLE.
- csr_addr is held at the latched address in all states (IDLE: last address).
- Out of reset, csr_addr = 0 and csr_wdata = 0.

## Timing
- Request accepted at edge E0:
  - csr_we high during E1–E2.
  - RAM write commits at E2.
  - rsp_valid rises after E2.
  - Earliest next accept is at the edge after the rsp handshake completes.
- Minimum occupancy is 4 cycles per instruction; there is no pipelining.
- req_ready and rsp_valid are never high together.
- Reset values (reset_n low):
  - State IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_rd_data=0, rsp_illegal=0.
  - csr_we=0, csr_addr=0, csr_wdata=0.
- Reset mid-operation:
  - The operation is aborted and the response is lost.
  - Reset asserted during WRITE drops csr_we immediately (asynchronously), so no write commits.
- rsp_ready held low: all response outputs are held unchanged indefinitely.
- A back-to-back request to the same address reads the value written by the previous request.

## Configuration
- CSR_RO_CHECK_EN
  - Defined:
    - An address with bits [ADDR_W-1:ADDR_W-2]=2'b11 (read-only CSR space) combined with an active write enable is illegal.
    - Result: no csr_we, rsp_illegal=1, rsp_rd_data=0.
    - Reads of that space with no write (RS/RC with rs1=0) remain legal.
  - Not defined: read-only space is written like any other address.
  - NUM must be 4096 when the macro is defined.

## Test plan
- CSRRW (001), addr 0x340, rs1_data 0xDEADBEEF, RAM holds 0x12345678 → rsp_rd_data 0x12345678 with rsp_valid 3 edges after accept; a following CSRRS rs1=0 to 0x340 returns 0xDEADBEEF.
- CSRRS (010), rs1=0, RAM holds 0xA5A5A5A5 → csr_we never asserted, rsp_rd_data 0xA5A5A5A5; then CSRRS rs1=3 with rs1_data 0x0000000F → writes 0xA5A5A5AF.
- CSRRCI (111), zimm 5'b00101, RAM holds 0x000000FF → csr_wdata 0x000000FA, rsp_rd_data 0x000000FF; funct3 100 → rsp_illegal=1, rsp_rd_data=0, no write.
- rsp_ready held low 5 cycles after rsp_valid → rsp_valid, rsp_rd_data and rsp_illegal stable; req_ready stays 0 with req_valid high; accept occurs only after the handshake.
- reset_n pulsed low during WRITE of a CSRRW to 0x300 → csr_we falls immediately, RAM[0x300] unchanged, req_ready=1, rsp_valid=0.
- With CSR_RO_CHECK_EN: CSRRW to 0xC00 → rsp_illegal=1, no write; CSRRS rs1=0 to 0xC00 → legal, returns stored value. Without the macro: the same CSRRW writes.

Source files
------------

// File: rtl/csr_access_unit.sv
// csr_access_unit: runs one Zicsr read-modify-write at a time against a synchronous-read CSR RAM.
// Optional feature macro CSR_RO_CHECK_EN: writes to read-only CSR space (addr top bits 2'b11) are illegal.
module csr_access_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NUM = 4096,
    localparam int unsigned ADDR_W = $clog2(NUM)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [4:0]        req_rs1,
    input  logic [XLEN-1:0]   req_rs1_data,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rd_data,
    output logic              rsp_illegal,
    output logic [ADDR_W-1:0] csr_addr,
    output logic              csr_we,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [XLEN-1:0] rs1_data;
    } req_t;

    state_t          state;
    state_t          state_nxt;
    req_t            req_q;
    logic            fire_c;
    logic [XLEN-1:0] operand_c;
    logic [XLEN-1:0] new_value_c;
    logic            op_legal_c;
    logic            wen_c;
    logic            ro_violation_c;
    logic            illegal_c;
    logic            write_en_c;

    assign fire_c = req_valid && req_ready;

    // Operand and new-value computation from the latched instruction fields.
    assign operand_c  = req_q.funct3[2] ? XLEN'(req_q.rs1) : req_q.rs1_data;
    assign op_legal_c = (req_q.funct3[1:0] != 2'b00);
    assign wen_c      = op_legal_c && ((req_q.funct3[1:0] == 2'b01) || (req_q.rs1 != 5'd0));

    always_comb begin
        new_value_c = csr_rdata;
        case (req_q.funct3[1:0])
            2'b01:   new_value_c = operand_c;
            2'b10:   new_value_c = csr_rdata | operand_c;
            2'b11:   new_value_c = csr_rdata & ~operand_c;
            default: new_value_c = csr_rdata;
        endcase
    end

`ifdef CSR_RO_CHECK_EN
    assign ro_violation_c = (csr_addr[ADDR_W-1 -: 2] == 2'b11) && wen_c;
`else
    assign ro_violation_c = 1'b0;
`endif

    assign illegal_c  = !op_legal_c || ro_violation_c;
    assign write_en_c = wen_c && !ro_violation_c;

    // State register; async reset drops csr_we immediately via the state decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        csr_we    = 1'b0;
        csr_wdata = '0;
        case (state)
            S_IDLE: begin
                if (fire_c) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                csr_we    = write_en_c;
                csr_wdata = new_value_c;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake flags registered from the next state so they are exact state decodes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            req_ready <= (state_nxt == S_IDLE);
            rsp_valid <= (state_nxt == S_RESP);
        end
    end

    // Request latch and response capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q       <= '0;
            csr_addr    <= '0;
            rsp_rd_data <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            if (fire_c) begin
                req_q.funct3   <= req_funct3;
                req_q.rs1      <= req_rs1;
                req_q.rs1_data <= req_rs1_data;
                csr_addr       <= req_addr;
            end
            if (state == S_WRITE) begin
                rsp_rd_data <= illegal_c ? '0 : csr_rdata;
                rsp_illegal <= illegal_c;
            end
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: directed vector table, reset/stall sequences, and random ops
// checked against a behavioural Zicsr model with a shadow CSR array.
module tb_csr_access_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NUM  = 4096;
    localparam int unsigned AW   = 12;

    logic            clock;
    logic            reset_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [4:0]      req_rs1;
    logic [XLEN-1:0] req_rs1_data;
    logic [AW-1:0]   req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rd_data;
    logic            rsp_illegal;
    logic [AW-1:0]   csr_addr;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;

    csr_access_unit #(.XLEN(XLEN), .NUM(NUM)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_rs1      (req_rs1),
        .req_rs1_data (req_rs1_data),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rd_data  (rsp_rd_data),
        .rsp_illegal  (rsp_illegal),
        .csr_addr     (csr_addr),
        .csr_we       (csr_we),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read CSR RAM with a backdoor write port for preloading.
    logic [XLEN-1:0] mem [NUM];
    logic            bd_we;
    logic [AW-1:0]   bd_addr;
    logic [XLEN-1:0] bd_data;

    always @(posedge clock) begin
        csr_rdata <= mem[csr_addr];
        if (csr_we) mem[csr_addr] = csr_wdata;
        if (bd_we) mem[bd_addr] = bd_data;
    end

    logic [XLEN-1:0] model_mem [NUM];
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %08h required %08h", name, act, exp);
        end
    endtask

    // Zicsr semantics straight from the instruction definition.
    function automatic void ref_model(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [31:0] d, input logic [11:0] a,
                                      input logic [31:0] old, output logic [31:0] nv,
                                      output logic we, output logic ill, output logic [31:0] rd);
        logic [31:0] opnd;
        int kind;
        opnd = f3[2] ? {27'd0, rs1} : d;
        kind = int'(f3) % 4;
        nv = old;
        we = 1'b0;
        ill = 1'b0;
        if (kind == 0) begin
            ill = 1'b1;
        end else begin
            we = (kind == 1) || (rs1 != 5'd0);
            if (kind == 1) nv = opnd;
            else if (kind == 2) nv = old | opnd;
            else nv = old & ~opnd;
        end
`ifdef CSR_RO_CHECK_EN
        if (we && a >= 12'hC00) begin
            ill = 1'b1;
            we = 1'b0;
        end
`endif
        rd = ill ? 32'd0 : old;
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        @(negedge clock);
        bd_we = 1'b1;
        bd_addr = a;
        bd_data = v;
        @(posedge clock);
        #1 bd_we = 1'b0;
        model_mem[a] = v;
    endtask

    // One full instruction; observed values returned, protocol timing checked inline.
    task automatic run_op(input logic [2:0] f3, input logic [4:0] rs1, input logic [31:0] d,
                          input logic [11:0] a, input int stall,
                          output logic [31:0] rd, output logic ill,
                          output logic we_seen, output logic [31:0] wd_seen);
        int cnt;
        rd = '0; ill = 1'b0; we_seen = 1'b0; wd_seen = '0;
        @(negedge clock);
        req_funct3 = f3; req_rs1 = rs1; req_rs1_data = d; req_addr = a;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        cnt = 0;
        while (!req_ready && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        if (cnt >= 20) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("ready_busy", 32'(req_ready), 32'd0);
        check("we_in_read", 32'(csr_we), 32'd0);
        check("rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        check("addr_write", 32'(csr_addr), 32'(a));
        we_seen = csr_we;
        wd_seen = csr_wdata;
        @(negedge clock);
        check("rsp_latency", 32'(rsp_valid), 32'd1);
        check("we_in_resp", 32'(csr_we), 32'd0);
        rd = rsp_rd_data;
        ill = rsp_illegal;
        if (stall > 0) req_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rd", rsp_rd_data, rd);
            check("stall_ill", 32'(rsp_illegal), 32'(ill));
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [31:0] d;
        logic [11:0] a;
        logic        pre_en;
        logic [31:0] pre;
        int          stall;
        logic [31:0] rd;
        logic        ill;
        logic        we;
        logic [31:0] wd;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] f3, input logic [4:0] rs1, input logic [31:0] d,
                                input logic [11:0] a, input logic pre_en, input logic [31:0] pre,
                                input int stall, input logic [31:0] rd, input logic ill,
                                input logic we, input logic [31:0] wd);
        vec_t v;
        v.f3 = f3; v.rs1 = rs1; v.d = d; v.a = a; v.pre_en = pre_en; v.pre = pre;
        v.stall = stall; v.rd = rd; v.ill = ill; v.we = we; v.wd = wd;
        return v;
    endfunction

    // Apply one op, compare against table expectations and the shadow array.
    task automatic apply_and_track(input vec_t v, input string tag, input logic use_table);
        logic [31:0] rd, wd, nv, mrd;
        logic ill, we, mwe, mill;
        ref_model(v.f3, v.rs1, v.d, v.a, model_mem[v.a], nv, mwe, mill, mrd);
        run_op(v.f3, v.rs1, v.d, v.a, v.stall, rd, ill, we, wd);
        if (!use_table) begin
            v.rd = mrd; v.ill = mill; v.we = mwe; v.wd = nv;
        end
        check({tag, "_rd"}, rd, v.rd);
        check({tag, "_ill"}, 32'(ill), 32'(v.ill));
        check({tag, "_we"}, 32'(we), 32'(v.we));
        if (v.we) check({tag, "_wdata"}, wd, v.wd);
        if (mwe) model_mem[v.a] = nv;
        check({tag, "_ram"}, mem[v.a], model_mem[v.a]);
    endtask

    vec_t vecs[$];
    logic [11:0] pool [8];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, wd;
        logic ill, we;
        reset_n = 1'b0;
        req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs1_data = '0; req_addr = '0;
        rsp_ready = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (2) @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rd_data", rsp_rd_data, 32'd0);
        check("rst_illegal", 32'(rsp_illegal), 32'd0);
        check("rst_we", 32'(csr_we), 32'd0);
        check("rst_addr", 32'(csr_addr), 32'd0);
        check("rst_wdata", csr_wdata, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        vecs.push_back(mk(3'b001, 5'd5, 32'hDEADBEEF, 12'h340, 1, 32'h12345678, 0, 32'h12345678, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(3'b010, 5'd0, 32'h0BADF00D, 12'h340, 0, 32'h0, 5, 32'hDEADBEEF, 0, 0, 32'h0));
        vecs.push_back(mk(3'b010, 5'd0, 32'h0, 12'h341, 1, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 0, 32'h0));
        vecs.push_back(mk(3'b010, 5'd3, 32'h0000000F, 12'h341, 0, 32'h0, 0, 32'hA5A5A5A5, 0, 1, 32'hA5A5A5AF));
        vecs.push_back(mk(3'b111, 5'b00101, 32'hFFFFFFFF, 12'h342, 1, 32'h000000FF, 0, 32'h000000FF, 0, 1, 32'h000000FA));
        vecs.push_back(mk(3'b100, 5'd5, 32'h1, 12'h342, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0));
        vecs.push_back(mk(3'b000, 5'd9, 32'h1, 12'h343, 1, 32'h00000077, 2, 32'h0, 1, 0, 32'h0));
        vecs.push_back(mk(3'b101, 5'd0, 32'h12345678, 12'h344, 1, 32'h0000FFFF, 0, 32'h0000FFFF, 0, 1, 32'h0));
        vecs.push_back(mk(3'b110, 5'd0, 32'hFFFFFFFF, 12'h345, 1, 32'h00001234, 0, 32'h00001234, 0, 0, 32'h0));
        vecs.push_back(mk(3'b011, 5'd7, 32'hF0F0F0F0, 12'h345, 0, 32'h0, 0, 32'h00001234, 0, 1, 32'h00000204));
        vecs.push_back(mk(3'b001, 5'd1, 32'hFFFFFFFF, 12'h000, 1, 32'h0, 0, 32'h0, 0, 1, 32'hFFFFFFFF));
`ifdef CSR_RO_CHECK_EN
        vecs.push_back(mk(3'b001, 5'd2, 32'h0000CAFE, 12'hC00, 1, 32'h00000001, 0, 32'h0, 1, 0, 32'h0));
        vecs.push_back(mk(3'b010, 5'd0, 32'h0, 12'hC00, 0, 32'h0, 0, 32'h00000001, 0, 0, 32'h0));
`else
        vecs.push_back(mk(3'b001, 5'd2, 32'h0000CAFE, 12'hC00, 1, 32'h00000001, 0, 32'h00000001, 0, 1, 32'h0000CAFE));
        vecs.push_back(mk(3'b010, 5'd0, 32'h0, 12'hC00, 0, 32'h0, 0, 32'h0000CAFE, 0, 0, 32'h0));
`endif

        foreach (vecs[i]) begin
            if (vecs[i].pre_en) preload(vecs[i].a, vecs[i].pre);
            apply_and_track(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end

        // Reset asserted during WRITE of a CSRRW to 0x300 must abort the write.
        preload(12'h300, 32'h11112222);
        @(negedge clock);
        req_funct3 = 3'b001; req_rs1 = 5'd4; req_rs1_data = 32'h55555555; req_addr = 12'h300;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rstmid_we_before", 32'(csr_we), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_we", 32'(csr_we), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd1);
        check("rstmid_rsp", 32'(rsp_valid), 32'd0);
        check("rstmid_addr", 32'(csr_addr), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        check("rstmid_ram", mem[12'h300], 32'h11112222);
        run_op(3'b010, 5'd0, 32'h0, 12'h300, 0, rd, ill, we, wd);
        check("rstmid_reread", rd, 32'h11112222);
        check("rstmid_reread_we", 32'(we), 32'd0);

        // Random ops over a small address pool, including both ends and the read-only region.
        pool[0] = 12'h000; pool[1] = 12'h001; pool[2] = 12'h300; pool[3] = 12'h340;
        pool[4] = 12'h7FF; pool[5] = 12'h800; pool[6] = 12'hC00; pool[7] = 12'hFFF;
        for (int i = 0; i < 8; i++) preload(pool[i], $urandom);
        for (int i = 0; i < 150; i++) begin
            vec_t v;
            v.f3 = 3'($urandom_range(0, 7));
            v.rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v.d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            v.a = pool[$urandom_range(0, 7)];
            v.pre_en = 1'b0; v.pre = '0;
            v.stall = $urandom_range(0, 2);
            v.rd = '0; v.ill = 1'b0; v.we = 1'b0; v.wd = '0;
            apply_and_track(v, $sformatf("rnd%0d", i), 1'b0);
        end
        for (int i = 0; i < 8; i++) check($sformatf("final_ram%0d", i), mem[pool[i]], model_mem[pool[i]]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
